// File: rtl/cp0_reg_pkg.sv
// Shared CP0 definitions: register addresses, exception codes, vectors and Status/Cause bit positions.
package cp0_reg_pkg;
  localparam int WORD_W = 32;
  localparam int EXC_W  = 5;
  localparam int ADDR_W = 5;

  localparam logic [ADDR_W-1:0] ADDR_BADVADDR = 5'd8;
  localparam logic [ADDR_W-1:0] ADDR_COUNT    = 5'd9;
  localparam logic [ADDR_W-1:0] ADDR_COMPARE  = 5'd11;
  localparam logic [ADDR_W-1:0] ADDR_STATUS   = 5'd12;
  localparam logic [ADDR_W-1:0] ADDR_CAUSE    = 5'd13;
  localparam logic [ADDR_W-1:0] ADDR_EPC      = 5'd14;

  localparam logic [EXC_W-1:0] EXC_INT  = 5'h00;
  localparam logic [EXC_W-1:0] EXC_ADEL = 5'h04;
  localparam logic [EXC_W-1:0] EXC_ADES = 5'h05;
  localparam logic [EXC_W-1:0] EXC_SYS  = 5'h08;
  localparam logic [EXC_W-1:0] EXC_BP   = 5'h09;
  localparam logic [EXC_W-1:0] EXC_RI   = 5'h0a;
  localparam logic [EXC_W-1:0] EXC_OV   = 5'h0c;
  localparam logic [EXC_W-1:0] EXC_NONE = 5'h10;
  localparam logic [EXC_W-1:0] EXC_ERET = 5'h11;

  localparam logic [WORD_W-1:0] VEC_BEV1 = 32'hBFC0_0380;
  localparam logic [WORD_W-1:0] VEC_BEV0 = 32'h8000_0180;

  localparam int ST_BEV = 22;
  localparam int ST_EXL = 1;
  localparam int ST_IE  = 0;
  localparam int CA_BD  = 31;
  localparam int CA_TI  = 30;

  function automatic logic is_exception(input logic [EXC_W-1:0] code);
    return (code != EXC_NONE) && (code != EXC_ERET);
  endfunction
endpackage

// File: rtl/cp0_reg_if.sv
// CP0 bus: MTC0/MFC0 access, exception inputs from the pipeline, and status/redirect outputs.
interface cp0_reg_if import cp0_reg_pkg::*;;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [WORD_W-1:0] wdata;
  logic [ADDR_W-1:0] raddr;
  logic [WORD_W-1:0] rdata;
  logic [EXC_W-1:0]  exccode;
  logic [WORD_W-1:0] pc_i;
  logic              in_delay;
  logic [WORD_W-1:0] badvaddr_i;
  logic [5:0]        int_i;
  logic [WORD_W-1:0] status_o;
  logic [WORD_W-1:0] cause_o;
  logic [WORD_W-1:0] epc_o;
  logic              flush;
  logic [WORD_W-1:0] exc_pc;

  modport master (
    output we, waddr, wdata, raddr, exccode, pc_i, in_delay, badvaddr_i, int_i,
    input  rdata, status_o, cause_o, epc_o, flush, exc_pc
  );
  modport slave (
    input  we, waddr, wdata, raddr, exccode, pc_i, in_delay, badvaddr_i, int_i,
    output rdata, status_o, cause_o, epc_o, flush, exc_pc
  );
endinterface

// File: rtl/cp0_timer.sv
// Count/Compare timer; Count advances at half clock rate. Only built with CP0_TIMER_INT_EN.
`ifdef CP0_TIMER_INT_EN
module cp0_timer import cp0_reg_pkg::*; (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_count_we,
  input  logic              i_compare_we,
  input  logic [WORD_W-1:0] i_wdata,
  output logic [WORD_W-1:0] o_count,
  output logic [WORD_W-1:0] o_compare,
  output logic              o_ti
);
  logic              r_tick;
  logic [WORD_W-1:0] r_count;
  logic [WORD_W-1:0] r_compare;
  logic              r_ti;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tick    <= 1'b0;
      r_count   <= '0;
      r_compare <= '0;
      r_ti      <= 1'b0;
    end else begin
      r_tick <= i_count_we ? 1'b0 : ~r_tick;
      if (i_count_we)
        r_count <= i_wdata;
      else if (r_tick)
        r_count <= r_count + 32'd1;
      // a Compare write acknowledges the interrupt and beats a coincident match
      if (i_compare_we) begin
        r_compare <= i_wdata;
        r_ti      <= 1'b0;
      end else if ((r_count == r_compare) && (r_compare != '0)) begin
        r_ti <= 1'b1;
      end
    end
  end

  assign o_count   = r_count;
  assign o_compare = r_compare;
  assign o_ti      = r_ti;
endmodule
`endif

// File: rtl/cp0_reg.sv
// CP0 register file with exception entry/ERET handling; timer interrupt enabled by CP0_TIMER_INT_EN.
module cp0_reg import cp0_reg_pkg::*; (
  input logic     clk,
  input logic     rst,
  cp0_reg_if.slave bus
);
  logic              w_exc, w_eret, w_mtc0, w_ti;
  logic [WORD_W-1:0] w_count, w_compare, w_status, w_cause, w_rdata;

  logic [WORD_W-1:0] r_epc, r_badvaddr;
  logic              r_bd, r_exl, r_ie, r_bev;
  logic [EXC_W-1:0]  r_exccode;
  logic [1:0]        r_ip_sw;
  logic [5:0]        r_ip_hw;
  logic [7:0]        r_im;

  assign w_exc  = is_exception(bus.exccode);
  assign w_eret = (bus.exccode == EXC_ERET);
  assign w_mtc0 = bus.we && !w_exc && !w_eret;

`ifdef CP0_TIMER_INT_EN
  cp0_timer u_timer (
    .clk          (clk),
    .rst          (rst),
    .i_count_we   (w_mtc0 && (bus.waddr == ADDR_COUNT)),
    .i_compare_we (w_mtc0 && (bus.waddr == ADDR_COMPARE)),
    .i_wdata      (bus.wdata),
    .o_count      (w_count),
    .o_compare    (w_compare),
    .o_ti         (w_ti)
  );
`else
  logic [WORD_W-1:0] r_count, r_compare;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count   <= '0;
      r_compare <= '0;
    end else if (w_mtc0) begin
      if (bus.waddr == ADDR_COUNT)   r_count   <= bus.wdata;
      if (bus.waddr == ADDR_COMPARE) r_compare <= bus.wdata;
    end
  end

  assign w_count   = r_count;
  assign w_compare = r_compare;
  assign w_ti      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_epc      <= '0;
      r_badvaddr <= '0;
      r_bd       <= 1'b0;
      r_exl      <= 1'b0;
      r_ie       <= 1'b0;
      r_bev      <= 1'b1;
      r_exccode  <= '0;
      r_ip_sw    <= '0;
      r_ip_hw    <= '0;
      r_im       <= '0;
    end else begin
      r_ip_hw <= bus.int_i;
      if (w_exc) begin
        // nested exceptions keep the outer return address and BD
        if (!r_exl) begin
          r_epc <= bus.in_delay ? (bus.pc_i - 32'd4) : bus.pc_i;
          r_bd  <= bus.in_delay;
          r_exl <= 1'b1;
        end
        r_exccode <= bus.exccode;
        if ((bus.exccode == EXC_ADEL) || (bus.exccode == EXC_ADES))
          r_badvaddr <= bus.badvaddr_i;
      end else if (w_eret) begin
        r_exl <= 1'b0;
      end else if (w_mtc0) begin
        case (bus.waddr)
          ADDR_STATUS: begin
            r_im  <= bus.wdata[15:8];
            r_exl <= bus.wdata[ST_EXL];
            r_ie  <= bus.wdata[ST_IE];
          end
          ADDR_CAUSE: r_ip_sw <= bus.wdata[9:8];
          ADDR_EPC:   r_epc   <= bus.wdata;
          default: ;
        endcase
      end
    end
  end

  assign w_status = {9'b0, r_bev, 6'b0, r_im, 6'b0, r_exl, r_ie};
  assign w_cause  = {r_bd, w_ti, 14'b0, r_ip_hw[5] | w_ti, r_ip_hw[4:0],
                     r_ip_sw, 1'b0, r_exccode, 2'b0};

  always_comb begin
    w_rdata = '0;
    case (bus.raddr)
      ADDR_BADVADDR: w_rdata = r_badvaddr;
      ADDR_COUNT:    w_rdata = w_count;
      ADDR_COMPARE:  w_rdata = w_compare;
      ADDR_STATUS:   w_rdata = w_status;
      ADDR_CAUSE:    w_rdata = w_cause;
      ADDR_EPC:      w_rdata = r_epc;
      default:       w_rdata = '0;
    endcase
    if (bus.we && (bus.waddr == bus.raddr))
      w_rdata = bus.wdata;
  end

  assign bus.rdata    = w_rdata;
  assign bus.status_o = w_status;
  assign bus.cause_o  = w_cause;
  assign bus.epc_o    = r_epc;
  assign bus.flush    = !rst && (w_exc || w_eret);
  assign bus.exc_pc   = w_eret ? r_epc :
                        w_exc  ? (r_bev ? VEC_BEV1 : VEC_BEV0) : '0;
endmodule

// File: doc/cp0_reg.md
CP0_REG -- requirements
Module: cp0_reg

Interface
REQ-001 SHALL provide ports: clk in 1 (rising-edge clock); rst in 1 (synchronous, active-high reset).
REQ-002 SHALL provide: we in 1, waddr in 5, wdata in 32 (MTC0 write); raddr in 5, rdata out 32 (MFC0 read).
REQ-003 SHALL provide: exccode in 5 (final code from exception control); pc_i in 32; in_delay in 1; badvaddr_i in 32; int_i in 6 (hardware interrupt lines).
REQ-004 SHALL provide: status_o out 32, cause_o out 32 (fed back to exception control); epc_o out 32; flush out 1; exc_pc out 32.
REQ-005 SHALL recognise these exccode values: INT 0x00, ADEL 0x04, ADES 0x05, SYS 0x08, BP 0x09, RI 0x0a, OV 0x0c, NONE 0x10, ERET 0x11.

Function
REQ-006 SHALL implement registers BadVAddr(8), Count(9), Compare(11), Status(12), Cause(13) and EPC(14); all other addresses read 0 and ignore writes.
REQ-007 SHALL limit MTC0-writable bits to: Status[15:8] IM, [1] EXL, [0] IE; Cause[9:8]; Count, Compare and EPC all bits. All other bits are read-only.
REQ-008 SHALL commit writes at the next rising edge; rdata is combinational, and returns wdata when we && waddr==raddr (same-cycle bypass).
REQ-009 SHALL register int_i into Cause[15:10] every cycle; Cause[15] = int_i[5] | Cause[30] (TI).
REQ-010 SHALL treat any exccode other than NONE or ERET as exception entry, taking effect at the next edge.
REQ-011 On entry with Status.EXL=0: EPC <= in_delay ? pc_i-4 : pc_i; Cause[31] BD <= in_delay; Status.EXL <= 1; Cause[6:2] <= exccode.
REQ-012 On entry with Status.EXL=1: EPC and BD SHALL be held; Cause[6:2] is still updated.
REQ-013 On ADEL/ADES: BadVAddr <= badvaddr_i; otherwise BadVAddr SHALL be held.
REQ-014 On ERET: Status.EXL <= 0 at the next edge; no other register changes.
REQ-015 flush SHALL be asserted combinationally in the same cycle as exception entry or ERET, and be 0 otherwise.
REQ-016 exc_pc SHALL be 0xBFC0_0380 on exception when Status[22] BEV=1, 0x8000_0180 when BEV=0, and the current EPC register value on ERET.
REQ-017 Priority SHALL be: rst > exception/ERET > MTC0 write; an MTC0 write in an exception or ERET cycle is discarded.
REQ-018 status_o, cause_o and epc_o SHALL be the registered values, with no write bypass.

Reset
REQ-019 On rst, SHALL set Status=0x0040_0000 (BEV=1), Cause=0, EPC=0, BadVAddr=0, Count=0, Compare=0, tick=0, TI=0.
REQ-020 During rst, flush=0 and rdata follows the reset values in the following cycle.
REQ-021 A reset asserted mid-exception SHALL override it; the register state afterwards is identical to REQ-019.

Configuration
REQ-022 Macro CP0_TIMER_INT_EN: when defined, a 1-bit tick toggles every cycle and Count increments when tick=1 (half clock rate).
REQ-023 With CP0_TIMER_INT_EN defined: TI is set at the edge after Count==Compare with Compare!=0; a Compare write clears TI and wins over a simultaneous match; a Count write sets tick=0.
REQ-024 Without CP0_TIMER_INT_EN: Count and Compare remain readable and writable but Count never increments, TI is constant 0 and Cause[15] = int_i[5].

Structure
REQ-025 Register addresses, exccode encodings, vector addresses and Status/Cause bit indices SHALL live in the shared defines file, alongside the existing word/exccode bus widths.
REQ-026 SHALL be a single module; the Count/Compare timer is a natural sub-module cp0_timer (outputs count, ti) when CP0_TIMER_INT_EN is defined.

Verification
REQ-027 Reset, then read every address -> Status=0x0040_0000, all others 0, flush=0.
REQ-028 MTC0 Status=0xFFFF_FFFF, then read -> 0x0040_FF03; same-cycle read of waddr returns 0xFFFF_FFFF via bypass.
REQ-029 exccode=OV, pc_i=0x8000_0010, in_delay=1, EXL=0 -> flush=1, exc_pc=0xBFC0_0380; next cycle EPC=0x8000_000C, Cause[31]=1, Cause[6:2]=0x0c, EXL=1.
REQ-030 With EXL=1, exccode=ADEL, badvaddr_i=0x1234_5671 -> EPC unchanged, Cause[6:2]=0x04, BadVAddr=0x1234_5671; then ERET -> flush=1, exc_pc=EPC, EXL=0 next cycle.
REQ-031 Timer (macro defined): Compare=20, Count=0 -> TI=1 and Cause[15]=1 about 40 cycles later; a Compare write the same cycle as the match -> TI stays 0.
REQ-032 MTC0 to EPC in the same cycle as exccode=SYS -> write discarded; EPC holds the exception pc_i value.
